inst_sram_bridge: RTL and testbench

Instruction-side responder for the fetch stage. It accepts the program-counter fetch request (`cpu_ce`, `cpu_addr`) and runs a sram-like read transaction (req / addr_ok / data_ok) toward the instruction bus. It returns the fetched word to IF and stalls the pipeline until that word is available. It sits between the PC register and the cache/AXI bridge.

---
 rtl/inst_sram_bridge_pkg.sv | 28 ++
 rtl/inst_sram_bridge_addr_map.sv | 20 ++
 rtl/inst_sram_bridge.sv | 115 +++++++++++
 tb/tb_inst_sram_bridge.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_sram_bridge_pkg.sv
// ============================================================================
// Module : inst_sram_bridge_pkg
// Brief  : Shared state encoding and address-map constants for the SRAM bridges
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package inst_sram_bridge_pkg;

  typedef enum logic [1:0] {
    IBR_IDLE = 2'd0,
    IBR_REQ  = 2'd1,
    IBR_WAIT = 2'd2,
    IBR_DONE = 2'd3
  } ibr_state_e;

  localparam logic [1:0]  c_SIZE_WORD = 2'b10;
  localparam logic [31:0] c_KSEG_MASK = 32'h1FFF_FFFF;

  // kseg0 and kseg1 both start with 2'b10 in the top bits.
  function automatic logic is_kseg01(input logic [31:0] vaddr);
    return (vaddr[31:30] == 2'b10);
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_sram_bridge_addr_map.sv
// ============================================================================
// Module : inst_sram_bridge_addr_map
// Brief  : Combinational virtual-to-physical translation (kseg0/kseg1 unmapped)
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module inst_sram_bridge_addr_map
  import inst_sram_bridge_pkg::*;
(
  input  logic [31:0] i_vaddr,
  output logic [31:0] o_paddr
);

  assign o_paddr = is_kseg01(i_vaddr) ? (i_vaddr & c_KSEG_MASK) : i_vaddr;

endmodule

`default_nettype wire

// File: rtl/inst_sram_bridge.sv
// ============================================================================
// Module : inst_sram_bridge
// Brief  : Fetch-side responder turning PC requests into sram-like bus reads
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module inst_sram_bridge
  import inst_sram_bridge_pkg::*;
#(
  parameter logic [31:0] RESET_DATA = 32'h0000_0000
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_longest_stall,
  input  logic        cpu_flush,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  ibr_state_e  r_state, w_state_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic        r_discard, w_discard_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;
  logic [31:0] w_paddr;
  logic        w_drop;

  inst_sram_bridge_addr_map u_addr_map (
    .i_vaddr (cpu_addr),
    .o_paddr (w_paddr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IBR_IDLE;
      r_addr    <= 32'h0;
      r_discard <= 1'b0;
      r_rdata   <= RESET_DATA;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_discard <= w_discard_nxt;
      r_rdata   <= w_rdata_nxt;
    end
  end

  // A flush in the same cycle as data_ok must also drop the word.
  assign w_drop = r_discard | cpu_flush;

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_discard_nxt = r_discard;
    w_rdata_nxt   = r_rdata;
    case (r_state)
      IBR_IDLE: begin
        if (cpu_ce && !cpu_flush) begin
          w_addr_nxt    = w_paddr;
          w_discard_nxt = 1'b0;
          w_state_nxt   = IBR_REQ;
        end
      end
      IBR_REQ: begin
        if (cpu_flush) w_discard_nxt = 1'b1;
        if (inst_addr_ok) begin
          if (inst_data_ok) begin
            if (w_drop) begin
              w_state_nxt = IBR_IDLE;
            end else begin
              w_rdata_nxt = inst_rdata;
              w_state_nxt = IBR_DONE;
            end
          end else begin
            w_state_nxt = IBR_WAIT;
          end
        end
      end
      IBR_WAIT: begin
        if (cpu_flush) w_discard_nxt = 1'b1;
        if (inst_data_ok) begin
          if (w_drop) begin
            w_state_nxt = IBR_IDLE;
          end else begin
            w_rdata_nxt = inst_rdata;
            w_state_nxt = IBR_DONE;
          end
        end
      end
      IBR_DONE: begin
        if (!cpu_longest_stall || cpu_flush) w_state_nxt = IBR_IDLE;
      end
      default: w_state_nxt = IBR_IDLE;
    endcase
  end

  assign inst_req  = (r_state == IBR_REQ);
  assign inst_wr   = 1'b0;
  assign inst_size = c_SIZE_WORD;
  assign inst_addr = r_addr;
  assign cpu_rdata = r_rdata;
  assign cpu_stall = cpu_ce & (r_state != IBR_DONE) & ~cpu_flush;

endmodule

`default_nettype wire

// File: tb/tb_inst_sram_bridge.sv
// ============================================================================
// Module : tb_inst_sram_bridge
// Brief  : Randomized transaction-level bench for inst_sram_bridge
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_inst_sram_bridge;

  localparam logic [31:0] TB_RESET_DATA = 32'h0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce;
  logic [31:0] cpu_addr;
  logic        cpu_longest_stall;
  logic        cpu_flush;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] m_last;

  inst_sram_bridge #(.RESET_DATA(TB_RESET_DATA)) dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_ce            (cpu_ce),
    .cpu_addr          (cpu_addr),
    .cpu_longest_stall (cpu_longest_stall),
    .cpu_flush         (cpu_flush),
    .cpu_rdata         (cpu_rdata),
    .cpu_stall         (cpu_stall),
    .inst_req          (inst_req),
    .inst_wr           (inst_wr),
    .inst_size         (inst_size),
    .inst_addr         (inst_addr),
    .inst_addr_ok      (inst_addr_ok),
    .inst_data_ok      (inst_data_ok),
    .inst_rdata        (inst_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference translation by address range rather than bit masking.
  function automatic logic [31:0] ref_xlate(input logic [31:0] va);
    if (va >= 32'h8000_0000 && va < 32'hA000_0000) return va - 32'h8000_0000;
    if (va >= 32'hA000_0000 && va < 32'hC000_0000) return va - 32'hA000_0000;
    return va;
  endfunction

  // Called just after a negedge with the bridge idle. ad = cycles before
  // addr_ok, dd = cycles from addr_ok to data_ok, hold = stall cycles after
  // completion. Returns just after a negedge with the bridge idle again.
  task automatic fetch(input logic [31:0] va, input logic [31:0] word,
                       input int ad, input int dd, input int hold, input bit do_flush);
    logic [31:0] pa;
    int          d_cyc;
    bit          flushed;
    pa      = ref_xlate(va);
    d_cyc   = ad + 2 + dd;
    flushed = do_flush && (dd > 0);
    cpu_ce = 1'b1; cpu_addr = va; cpu_flush = 1'b0; cpu_longest_stall = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    #1;
    chk("idle_stall", cpu_stall, 32'd1);
    chk("idle_req", inst_req, 32'd0);
    chk("idle_rdata", cpu_rdata, m_last);
    for (int k = 1; k < d_cyc; k++) begin
      @(negedge clk);
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; cpu_flush = 1'b0;
      inst_rdata = $urandom;
      if (k <= ad + 1) begin
        if (k == ad + 1) begin
          inst_addr_ok = 1'b1;
          if (dd == 0) begin inst_data_ok = 1'b1; inst_rdata = word; end
        end else begin
          inst_data_ok = 1'($urandom_range(0, 1));
        end
        #1;
        chk("req_high", inst_req, 32'd1);
        chk("req_addr", inst_addr, pa);
        chk("req_stall", cpu_stall, 32'd1);
      end else begin
        if (flushed && k == ad + 2) cpu_flush = 1'b1;
        if (k == ad + 1 + dd) begin inst_data_ok = 1'b1; inst_rdata = word; end
        #1;
        chk("wait_req", inst_req, 32'd0);
        chk("wait_stall", cpu_stall, {31'd0, ~cpu_flush});
      end
    end
    @(negedge clk);
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; cpu_flush = 1'b0;
    if (flushed) begin
      #1;
      chk("flush_stall", cpu_stall, 32'd1);
      chk("flush_req", inst_req, 32'd0);
      chk("flush_rdata", cpu_rdata, m_last);
      return;
    end
    m_last = word;
    cpu_longest_stall = (hold > 0);
    #1;
    chk("done_stall", cpu_stall, 32'd0);
    chk("done_rdata", cpu_rdata, word);
    chk("done_req", inst_req, 32'd0);
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      cpu_longest_stall = (h < hold);
      #1;
      chk("hold_stall", cpu_stall, 32'd0);
      chk("hold_rdata", cpu_rdata, word);
      chk("hold_req", inst_req, 32'd0);
    end
    @(negedge clk);
    cpu_longest_stall = 1'b0;
    #1;
    chk("after_stall", cpu_stall, 32'd1);
    chk("after_req", inst_req, 32'd0);
  endtask

  task automatic gap(input int n);
    cpu_ce = 1'b0;
    repeat (n) @(negedge clk);
    #1;
    chk("gap_req", inst_req, 32'd0);
    chk("gap_stall", cpu_stall, 32'd0);
    chk("gap_rdata", cpu_rdata, m_last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_ce = 1'b0; cpu_addr = 32'h0; cpu_flush = 1'b0;
    cpu_longest_stall = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    inst_rdata = 32'h0;
    m_last = TB_RESET_DATA;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", inst_req, 32'd0);
    chk("rst_stall_ce0", cpu_stall, 32'd0);
    chk("rst_rdata", cpu_rdata, TB_RESET_DATA);
    chk("rst_wr", inst_wr, 32'd0);
    chk("rst_size", inst_size, 32'd2);
    cpu_ce = 1'b1;
    #1;
    chk("rst_stall_ce1", cpu_stall, 32'd1);
    cpu_ce = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    fetch(32'hbfc0_0000, 32'h3c08_0001, 0, 0, 0, 1'b0);
    fetch(32'h0040_0000, 32'h1234_5678, 2, 3, 0, 1'b0);
    fetch(32'h8000_0100, $urandom, 1, 1, 4, 1'b0);
    fetch(32'hbfc0_0200, $urandom, 1, 2, 0, 1'b1);
    fetch(32'hbfc0_0380, $urandom, 0, 1, 0, 1'b0);
    fetch(32'h9fc0_0010, $urandom, 0, 0, 1, 1'b0);
    gap(2);

    for (int i = 0; i < 30; i++) begin
      int ad, dd;
      ad = $urandom_range(0, 3);
      dd = $urandom_range(0, 3);
      fetch($urandom, $urandom, ad, dd, $urandom_range(0, 3),
            1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 2));
    end

    // Asynchronous reset while a request is outstanding.
    cpu_ce = 1'b1; cpu_addr = 32'ha000_0040;
    @(negedge clk);
    #1;
    chk("arst_req_before", inst_req, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", inst_req, 32'd0);
    chk("arst_stall", cpu_stall, 32'd1);
    chk("arst_rdata", cpu_rdata, TB_RESET_DATA);
    m_last = TB_RESET_DATA;
    @(negedge clk);
    rst = 1'b0; cpu_ce = 1'b0;
    @(negedge clk);
    fetch(32'h8000_0040, 32'hcafe_0001, 0, 0, 0, 1'b0);
    gap(1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
